mcyc_seq: RTL and testbench
===========================

Name: mcyc_seq

Overview:
- Parametrised machine-cycle / T-state sequencer for the 8085-class core.
- Consumes the decoded instruction info from the ALU/register datapath (extra-cycle mask, write mask, 6-T flag, halt, condition status).
- Generates per-T-state bus strobes and datapath enables: opcode latch, data latch, PC increment.
- Generalises the fixed 5-cycle scheme: machine-cycle depth is set by parameter, and the block adds wait-state insertion, conditional cycle trimming and a halt state.

Parameters:
- CYCMAX, 5, maximum machine cycles per instruction (M1..M<CYCMAX>); legal range 2..8.
- MASKSIZE, CYCMAX-1, width of the extra-cycle and write masks (bit k describes M(k+2)).
- CYCBITS, 3, width of the machine-cycle index; must satisfy 2**CYCBITS >= CYCMAX.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- ready  in  1  bus ready, sampled in T2 and TW.
- wake  in  1  leave HALT.
- inst_cyc  in  MASKSIZE  thermometer mask of extra machine cycles (bit k = M(k+2) present).
- inst_rw  in  MASKSIZE  bit k = M(k+2) is a write cycle.
- inst_go6  in  1  M1 takes 6 T-states.
- inst_hlt  in  1  halt instruction.
- inst_dio  in  1  I/O instruction; its last extra cycle is an I/O cycle.
- inst_cnd  in  1  conditional instruction.
- inst_ccc  in  1  condition true.
- cnd_keep  in  CYCBITS  extra cycles kept when the condition is false.
- mcyc  out  CYCBITS  current machine cycle, 0 = M1.
- tst  out  3  T-state code: 1..6 = T1..T6, 7 = TW, 0 = HALT.
- ale  out  1  address latch enable.
- rd_  out  1  read strobe, active low.
- wr_  out  1  write strobe, active low.
- iom  out  1  1 = I/O cycle.
- enb_c  out  1  latch opcode into the instruction register.
- enb_d  out  1  latch data into the temp register.
- enbpc  out  1  PC increment enable.
- done  out  1  final T-state of the instruction.

Behaviour:
- Reset (rst=1 at a clock edge):
  - Next state is M1/T1: mcyc=0, tst=1.
  - ale=1 (T1 decode), rd_=1, wr_=1, iom=0, enb_c=0, enb_d=0, enbpc=0, done=0.
  - Latched info is cleared.
  - Reset mid-cycle or in HALT aborts immediately; no strobe glitches low.
- All outputs are registered or decoded from registered state. No output depends combinationally on ready.
- T1:
  - ale=1; iom valid for the whole cycle.
  - Next state is T2.
- T2:
  - rd_=0 for M1 and for read cycles; wr_=0 for write cycles.
  - enbpc=1 in M1 only.
  - ready=0 → TW; ready=1 → T3.
- TW:
  - Strobes held.
  - Re-sample ready each clock; ready=1 → T3. No wait limit.
- T3:
  - Strobes held.
  - enb_c=1 in M1; enb_d=1 in read cycles of M2 and later.
  - Strobes go high on exit from T3.
- T4 (M1 only):
  - Inputs are sampled and latched here; they must be valid in T4.
  - Extra cycles N = index of the highest set bit of inst_cyc, plus 1 (0 if the mask is all-zero).
  - If inst_cnd=1 and inst_ccc=0: N = min(N, cnd_keep).
  - Next state:
    - inst_go6=1 → T5, T6.
    - Otherwise, inst_hlt=1 → HALT.
    - Otherwise, N>0 → M2/T1.
    - Otherwise → M1/T1.
  - done=1 in T4 when M1 is the final cycle and go6=0.
- T5, T6:
  - No strobes.
  - Exit from T6 follows the same HALT / M2 / M1 rules as T4.
  - done=1 in T6 if N=0.
- Mk, k>=2:
  - Sequence T1 → T2 → [TW]* → T3.
  - Write cycle if latched inst_rw[k-2]=1.
  - iom=1 only when inst_dio=1 and k is the last cycle.
  - After T3: next M if k-1 < N, else M1/T1 with done=1 in that T3.
- HALT:
  - tst=0; all strobes inactive; ale=0.
  - wake=1 → M1/T1 next clock. rst also exits.
- Bits of inst_cyc/inst_rw above the MASKSIZE range do not exist. Non-thermometer masks use the highest set bit only.

Test Plan:
- Reset, then ready=1, inst_cyc=0, go6=0 → tst sequence 1,2,3,4 repeating; rd_ low in T2–T3; enb_c=1 in T3; enbpc=1 in T2; done=1 in T4.
- inst_cyc=4'b0011, inst_rw=4'b0010 (STAX-like) → M1 (4T), M2 read (enb_d in T3), M3 write (wr_ low T2–T3, rd_ high); done in M3/T3; 10 clocks total.
- ready held low 3 clocks in M2/T2 → three TW states (tst=7) with rd_ held low; T3 follows the first clock with ready=1; mcyc stays 1 throughout.
- Conditional: inst_cyc=4'b1111, inst_cnd=1, go6=1, inst_ccc=0, cnd_keep=0 → M1 T1–T6 only, done=1 in T6. Repeat with ccc=1 → cycles M1..M5, 6+4×3 = 18 clocks.
- inst_hlt=1 → HALT (tst=0) after T4; stays 10 clocks with wake=0; wake=1 → M1/T1 next clock.
- rst asserted in M3/T2 of a write cycle → next clock M1/T1, wr_=1, done=0, and latched masks cleared.

Source files
------------

// File: rtl/mcyc_seq.sv
// mcyc_seq: machine-cycle / T-state sequencer for an 8085-class core.
// Steps through M1..M<CYCMAX> and T1..T6/TW/HALT. It produces the bus strobes
// (ale, rd_, wr_, iom) and the datapath enables (enb_c, enb_d, enbpc). The
// decoded instruction info is sampled in M1/T4.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   ready            bus ready, sampled in T2/TW
//   wake             leave HALT
//   inst_cyc/rw      extra-cycle mask / write mask (bit k = M(k+2))
//   inst_go6/hlt/dio/cnd/ccc, cnd_keep   decoded instruction info
//   mcyc, tst        current machine cycle (0 = M1) and T-state code
//   ale, rd_, wr_, iom, enb_c, enb_d, enbpc, done   strobes and enables
module mcyc_seq #(
    parameter int unsigned CYCMAX   = 5,
    parameter int unsigned MASKSIZE = CYCMAX - 1,
    parameter int unsigned CYCBITS  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ready,
    input  logic                wake,
    input  logic [MASKSIZE-1:0] inst_cyc,
    input  logic [MASKSIZE-1:0] inst_rw,
    input  logic                inst_go6,
    input  logic                inst_hlt,
    input  logic                inst_dio,
    input  logic                inst_cnd,
    input  logic                inst_ccc,
    input  logic [CYCBITS-1:0]  cnd_keep,
    output logic [CYCBITS-1:0]  mcyc,
    output logic [2:0]          tst,
    output logic                ale,
    output logic                rd_,
    output logic                wr_,
    output logic                iom,
    output logic                enb_c,
    output logic                enb_d,
    output logic                enbpc,
    output logic                done
);

    typedef enum logic [2:0] {
        TS_HALT = 3'd0,
        TS_T1   = 3'd1,
        TS_T2   = 3'd2,
        TS_T3   = 3'd3,
        TS_T4   = 3'd4,
        TS_T5   = 3'd5,
        TS_T6   = 3'd6,
        TS_TW   = 3'd7
    } tstate_t;

    // State and latched instruction info
    logic [CYCBITS-1:0]  r_mcyc;
    tstate_t             r_tst;
    logic [CYCBITS-1:0]  r_n;
    logic [MASKSIZE-1:0] r_rw;
    logic                r_dio;
    logic                r_hlt;

    // Registered outputs
    logic r_ale, r_rd_n, r_wr_n, r_iom, r_enb_c, r_enb_d, r_enbpc, r_done;

    // Next-state values
    logic [CYCBITS-1:0]  w_nxt_mcyc;
    tstate_t             w_nxt_tst;
    logic [CYCBITS-1:0]  w_nxt_n;
    logic [MASKSIZE-1:0] w_nxt_rw;
    logic                w_nxt_dio;
    logic                w_nxt_hlt;

    // Extra-cycle count derived from the live instruction inputs
    logic [CYCBITS-1:0]  w_n_raw;
    logic [CYCBITS-1:0]  w_n_in;

    // Output decode of the next state
    logic w_act, w_wr, w_ale, w_rd_n, w_wr_n, w_iom;
    logic w_enb_c, w_enb_d, w_enbpc, w_done, w_done_t4;

    // Write-cycle lookup: machine-cycle index m (1 = M2) selects rw[m-1]
    function automatic logic f_is_wr(input logic [MASKSIZE-1:0] rw,
                                     input logic [CYCBITS-1:0]  m);
        logic v;
        v = 1'b0;
        for (int k = 0; k < int'(MASKSIZE); k++) begin
            if (m == CYCBITS'(k + 1)) v = rw[k];
        end
        return v;
    endfunction

    // Highest set bit of inst_cyc (plus one); non-thermometer masks collapse to it
    always_comb begin
        w_n_raw = '0;
        for (int k = 0; k < int'(MASKSIZE); k++) begin
            if (inst_cyc[k]) w_n_raw = CYCBITS'(k + 1);
        end
    end

    // A false condition trims the extra cycles down to cnd_keep
    always_comb begin
        w_n_in = w_n_raw;
        if (inst_cnd && !inst_ccc && (cnd_keep < w_n_raw)) w_n_in = cnd_keep;
    end

    // Next-state logic
    always_comb begin
        w_nxt_mcyc = r_mcyc;
        w_nxt_tst  = r_tst;
        w_nxt_n    = r_n;
        w_nxt_rw   = r_rw;
        w_nxt_dio  = r_dio;
        w_nxt_hlt  = r_hlt;
        case (r_tst)
            TS_T1: w_nxt_tst = TS_T2;
            TS_T2,
            TS_TW: w_nxt_tst = ready ? TS_T3 : TS_TW;
            TS_T3: begin
                if (r_mcyc == '0) begin
                    w_nxt_tst = TS_T4;
                end else if (r_mcyc < r_n) begin
                    w_nxt_mcyc = r_mcyc + CYCBITS'(1);
                    w_nxt_tst  = TS_T1;
                end else begin
                    w_nxt_mcyc = '0;
                    w_nxt_tst  = TS_T1;
                end
            end
            TS_T4: begin
                // Decoded opcode info is captured for the rest of the instruction
                w_nxt_n   = w_n_in;
                w_nxt_rw  = inst_rw;
                w_nxt_dio = inst_dio;
                w_nxt_hlt = inst_hlt;
                if (inst_go6) begin
                    w_nxt_tst = TS_T5;
                end else if (inst_hlt) begin
                    w_nxt_tst = TS_HALT;
                end else if (w_n_in != '0) begin
                    w_nxt_mcyc = CYCBITS'(1);
                    w_nxt_tst  = TS_T1;
                end else begin
                    w_nxt_tst = TS_T1;
                end
            end
            TS_T5: w_nxt_tst = TS_T6;
            TS_T6: begin
                if (r_hlt) begin
                    w_nxt_tst = TS_HALT;
                end else if (r_n != '0) begin
                    w_nxt_mcyc = CYCBITS'(1);
                    w_nxt_tst  = TS_T1;
                end else begin
                    w_nxt_tst = TS_T1;
                end
            end
            TS_HALT: begin
                w_nxt_mcyc = '0;
                if (wake) w_nxt_tst = TS_T1;
            end
            default: begin
                w_nxt_mcyc = '0;
                w_nxt_tst  = TS_T1;
            end
        endcase
    end

    // Outputs for the state being entered, so they register cleanly
    always_comb begin
        w_act   = (w_nxt_tst == TS_T2) || (w_nxt_tst == TS_T3) || (w_nxt_tst == TS_TW);
        w_wr    = (w_nxt_mcyc != '0) && f_is_wr(w_nxt_rw, w_nxt_mcyc);
        w_ale   = (w_nxt_tst == TS_T1);
        w_rd_n  = !(w_act && !w_wr);
        w_wr_n  = !(w_act && w_wr);
        w_iom   = (w_nxt_mcyc != '0) && (w_nxt_tst != TS_HALT) && w_nxt_dio
                  && (w_nxt_mcyc == w_nxt_n);
        w_enbpc = (w_nxt_tst == TS_T2) && (w_nxt_mcyc == '0);
        w_enb_c = (w_nxt_tst == TS_T3) && (w_nxt_mcyc == '0);
        w_enb_d = (w_nxt_tst == TS_T3) && (w_nxt_mcyc != '0) && !w_wr;
        w_done  = ((w_nxt_tst == TS_T6) && ((w_nxt_n == '0) || w_nxt_hlt))
                  || ((w_nxt_tst == TS_T3) && (w_nxt_mcyc != '0)
                      && (w_nxt_mcyc == w_nxt_n));
    end

    // Decoded info only becomes valid during T4 itself, so done in M1/T4 is
    // decoded from the T4 state and the live instruction inputs (never ready).
    always_comb begin
        w_done_t4 = (r_tst == TS_T4) && (r_mcyc == '0) && !inst_go6
                    && (inst_hlt || (w_n_in == '0));
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcyc  <= '0;
            r_tst   <= TS_T1;
            r_n     <= '0;
            r_rw    <= '0;
            r_dio   <= 1'b0;
            r_hlt   <= 1'b0;
            r_ale   <= 1'b1;
            r_rd_n  <= 1'b1;
            r_wr_n  <= 1'b1;
            r_iom   <= 1'b0;
            r_enb_c <= 1'b0;
            r_enb_d <= 1'b0;
            r_enbpc <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_mcyc  <= w_nxt_mcyc;
            r_tst   <= w_nxt_tst;
            r_n     <= w_nxt_n;
            r_rw    <= w_nxt_rw;
            r_dio   <= w_nxt_dio;
            r_hlt   <= w_nxt_hlt;
            r_ale   <= w_ale;
            r_rd_n  <= w_rd_n;
            r_wr_n  <= w_wr_n;
            r_iom   <= w_iom;
            r_enb_c <= w_enb_c;
            r_enb_d <= w_enb_d;
            r_enbpc <= w_enbpc;
            r_done  <= w_done;
        end
    end

    assign mcyc  = r_mcyc;
    assign tst   = r_tst;
    assign ale   = r_ale;
    assign rd_   = r_rd_n;
    assign wr_   = r_wr_n;
    assign iom   = r_iom;
    assign enb_c = r_enb_c;
    assign enb_d = r_enb_d;
    assign enbpc = r_enbpc;
    assign done  = r_done | w_done_t4;

endmodule

// File: tb/tb_mcyc_seq.sv
// Testbench for mcyc_seq: per-instruction expected T-state traces built from
// the sequencing rules, checked clock by clock by an independent monitor.
module tb_mcyc_seq;

    localparam int unsigned CYCMAX   = 5;
    localparam int unsigned MASKSIZE = 4;
    localparam int unsigned CYCBITS  = 3;

    logic                clk;
    logic                rst;
    logic                ready;
    logic                wake;
    logic [MASKSIZE-1:0] inst_cyc;
    logic [MASKSIZE-1:0] inst_rw;
    logic                inst_go6, inst_hlt, inst_dio, inst_cnd, inst_ccc;
    logic [CYCBITS-1:0]  cnd_keep;
    logic [CYCBITS-1:0]  mcyc;
    logic [2:0]          tst;
    logic                ale, rd_, wr_, iom, enb_c, enb_d, enbpc, done;

    mcyc_seq #(.CYCMAX(CYCMAX), .MASKSIZE(MASKSIZE), .CYCBITS(CYCBITS)) dut (
        .clk(clk), .rst(rst), .ready(ready), .wake(wake),
        .inst_cyc(inst_cyc), .inst_rw(inst_rw), .inst_go6(inst_go6),
        .inst_hlt(inst_hlt), .inst_dio(inst_dio), .inst_cnd(inst_cnd),
        .inst_ccc(inst_ccc), .cnd_keep(cnd_keep),
        .mcyc(mcyc), .tst(tst), .ale(ale), .rd_(rd_), .wr_(wr_), .iom(iom),
        .enb_c(enb_c), .enb_d(enb_d), .enbpc(enbpc), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] mcyc;
        logic [2:0] tst;
        logic       ale;
        logic       rd_n;
        logic       wr_n;
        logic       iom;
        logic       enb_c;
        logic       enb_d;
        logic       enbpc;
        logic       done;
    } rec_t;

    rec_t exp_q[$];
    rec_t plan[$];
    int   total = 0;
    int   bad   = 0;
    int   waits[8];
    bit   sim_end = 1'b0;

    function automatic rec_t mk(input int m, input int t, input bit a, input bit rl,
                                input bit wl, input bit io, input bit ec, input bit ed,
                                input bit pc, input bit dn);
        rec_t r;
        r.mcyc = 3'(m);  r.tst = 3'(t);  r.ale = a;   r.rd_n = rl;
        r.wr_n = wl;     r.iom = io;     r.enb_c = ec; r.enb_d = ed;
        r.enbpc = pc;    r.done = dn;
        return r;
    endfunction

    // Expected clock-by-clock trace of one instruction
    task automatic build(input logic [3:0] cyc, input logic [3:0] rw, input bit go6,
                         input bit hlt, input bit dio, input bit cnd, input bit ccc,
                         input int keep, input int halt_len);
        int n;
        bit w, last, io;
        plan.delete();
        n = 0;
        for (int k = 0; k < 4; k++) if (cyc[k]) n = k + 1;
        if (cnd && !ccc && keep < n) n = keep;
        plan.push_back(mk(0, 1, 1, 1, 1, 0, 0, 0, 0, 0));
        plan.push_back(mk(0, 2, 0, 0, 1, 0, 0, 0, 1, 0));
        repeat (waits[0]) plan.push_back(mk(0, 7, 0, 0, 1, 0, 0, 0, 0, 0));
        plan.push_back(mk(0, 3, 0, 0, 1, 0, 1, 0, 0, 0));
        plan.push_back(mk(0, 4, 0, 1, 1, 0, 0, 0, 0, !go6 && (hlt || n == 0)));
        if (go6) begin
            plan.push_back(mk(0, 5, 0, 1, 1, 0, 0, 0, 0, 0));
            plan.push_back(mk(0, 6, 0, 1, 1, 0, 0, 0, 0, hlt || n == 0));
        end
        if (hlt) begin
            repeat (halt_len) plan.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        end else begin
            for (int k = 2; k <= n + 1; k++) begin
                w    = rw[k-2];
                last = (k == n + 1);
                io   = dio && last;
                plan.push_back(mk(k-1, 1, 1, 1, 1, io, 0, 0, 0, 0));
                plan.push_back(mk(k-1, 2, 0, w, !w, io, 0, 0, 0, 0));
                repeat (waits[k-1]) plan.push_back(mk(k-1, 7, 0, w, !w, io, 0, 0, 0, 0));
                plan.push_back(mk(k-1, 3, 0, w, !w, io, 0, !w, 0, last));
            end
        end
    endtask

    // Issue one instruction; optionally reset at the first (abort_m, abort_t) clock
    task automatic run_inst(input logic [3:0] cyc, input logic [3:0] rw, input bit go6,
                            input bit hlt, input bit dio, input bit cnd, input bit ccc,
                            input int keep, input int halt_len,
                            input int abort_m, input int abort_t);
        int ab;
        int last_i;
        ab = -1;
        inst_cyc = cyc; inst_rw = rw; inst_go6 = go6; inst_hlt = hlt;
        inst_dio = dio; inst_cnd = cnd; inst_ccc = ccc; cnd_keep = 3'(keep);
        build(cyc, rw, go6, hlt, dio, cnd, ccc, keep, halt_len);
        if (abort_m >= 0) begin
            for (int i = 0; i < plan.size(); i++)
                if (ab < 0 && plan[i].mcyc == 3'(abort_m) && plan[i].tst == 3'(abort_t)) ab = i;
        end
        last_i = (ab >= 0) ? ab : plan.size() - 1;
        for (int i = 0; i <= last_i; i++) exp_q.push_back(plan[i]);
        for (int i = 0; i <= last_i; i++) begin
            if (plan[i].tst == 3'd2 || plan[i].tst == 3'd7)
                ready = (plan[i+1].tst != 3'd7);
            else
                ready = 1'($urandom_range(0, 1));
            if (plan[i].tst == 3'd0) wake = (i + 1 == plan.size());
            else                     wake = 1'($urandom_range(0, 1));
            rst = (i == ab);
            @(posedge clk);
            #1;
            rst = 1'b0;
        end
    endtask

    // Monitor: one expected record per clock, sampled mid-cycle
    always @(negedge clk) begin
        rec_t e, a;
        if (!sim_end && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {mcyc, tst, ale, rd_, wr_, iom, enb_c, enb_d, enbpc, done};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL trace t=%0t: got m=%0d t=%0d ale/rd/wr/iom/c/d/pc/done=%b%b%b%b%b%b%b%b want m=%0d t=%0d %b%b%b%b%b%b%b%b",
                         $time, a.mcyc, a.tst, a.ale, a.rd_n, a.wr_n, a.iom, a.enb_c,
                         a.enb_d, a.enbpc, a.done, e.mcyc, e.tst, e.ale, e.rd_n,
                         e.wr_n, e.iom, e.enb_c, e.enb_d, e.enbpc, e.done);
            end
        end
    end

    task automatic clear_waits();
        for (int i = 0; i < 8; i++) waits[i] = 0;
    endtask

    initial begin
        logic [3:0] c, r;
        int nw;
        rst = 1'b1; ready = 1'b1; wake = 1'b0;
        inst_cyc = '0; inst_rw = '0; inst_go6 = 1'b0; inst_hlt = 1'b0;
        inst_dio = 1'b0; inst_cnd = 1'b0; inst_ccc = 1'b0; cnd_keep = '0;
        clear_waits();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single-cycle opcodes
        repeat (3) run_inst(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 1, -1, -1);
        // Read then write (STAX-like)
        run_inst(4'b0011, 4'b0010, 0, 0, 0, 0, 0, 0, 1, -1, -1);
        // Three wait states in M2
        waits[1] = 3;
        run_inst(4'b0001, 4'b0000, 0, 0, 0, 0, 0, 0, 1, -1, -1);
        clear_waits();
        // Conditional, condition false then true
        run_inst(4'b1111, 4'b0000, 1, 0, 0, 1, 0, 0, 1, -1, -1);
        run_inst(4'b1111, 4'b0000, 1, 0, 0, 1, 1, 0, 1, -1, -1);
        // Halt for ten clocks, then wake
        run_inst(4'b0000, 4'b0000, 0, 1, 0, 0, 0, 0, 11, -1, -1);
        // Reset in M3/T2 of a write cycle, then check clean restart
        run_inst(4'b0011, 4'b0010, 0, 0, 0, 0, 0, 0, 1, 2, 2);
        run_inst(4'b0000, 4'b0000, 1, 0, 0, 0, 0, 0, 1, -1, -1);
        // I/O instruction: last extra cycle has iom
        run_inst(4'b0011, 4'b0001, 0, 0, 1, 0, 0, 0, 1, -1, -1);
        // Non-thermometer mask and partial condition trim
        run_inst(4'b0101, 4'b1010, 0, 0, 0, 1, 0, 2, 1, -1, -1);

        // Randomized instructions
        repeat (300) begin
            for (int i = 0; i < 8; i++) begin
                nw = int'($urandom_range(0, 3));
                waits[i] = (nw == 3) ? int'($urandom_range(1, 3)) : 0;
            end
            if ($urandom_range(0, 1) == 1) c = 4'((1 << $urandom_range(0, 4)) - 1);
            else                           c = 4'($urandom);
            r = 4'($urandom);
            if ($urandom_range(0, 19) == 0)
                run_inst(c, r, 1'($urandom), 1'($urandom_range(0, 7) == 0), 1'($urandom),
                         1'($urandom), 1'($urandom), int'($urandom_range(0, 7)),
                         int'($urandom_range(1, 6)),
                         int'($urandom_range(0, 4)), int'($urandom_range(1, 7)));
            else
                run_inst(c, r, 1'($urandom), 1'($urandom_range(0, 7) == 0), 1'($urandom),
                         1'($urandom), 1'($urandom), int'($urandom_range(0, 7)),
                         int'($urandom_range(1, 6)), -1, -1);
        end

        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d records left, want 0", exp_q.size());
        end
        sim_end = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
